// File: rtl/local_branch_predictor.sv
// local_branch_predictor: two-level local predictor (per-PC history + shared 2-bit PHT) with mispredict flag and stats
//   clk, rst                 clock, async active-high reset
//   pred_pc -> pred_taken, pred_hist      combinational fetch lookup
//   upd_valid, upd_pc, upd_br_en, upd_hist, upd_pred_taken   execute-stage training
//   mispredict, branch_cnt, mispred_cnt   registered pulse and saturating counters
module local_branch_predictor #(
  parameter int LHT_IDX_BITS = 5,
  parameter int HIST_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [HIST_BITS-1:0] pred_hist,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_br_en,
  input  logic [HIST_BITS-1:0] upd_hist,
  input  logic                 upd_pred_taken,
  output logic                 mispredict,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispred_cnt
);
  localparam int LHT_N = 1 << LHT_IDX_BITS;
  localparam int PHT_N = 1 << HIST_BITS;
  logic [HIST_BITS-1:0] lht_q [LHT_N];
  logic [1:0] pht_q [PHT_N];
  logic mispredict_q;
  logic [31:0] branch_cnt_q, mispred_cnt_q, branch_cnt_d, mispred_cnt_d;
  logic [LHT_IDX_BITS-1:0] pred_idx, upd_idx;
  logic [HIST_BITS-1:0] lht_d;
  logic [1:0] pht_cur, pht_d;
  logic miss;
  logic unused_pc_bits;
  assign pred_idx = pred_pc[LHT_IDX_BITS+1:2];
  assign upd_idx = upd_pc[LHT_IDX_BITS+1:2];
  assign unused_pc_bits = ^{pred_pc[31:LHT_IDX_BITS+2], pred_pc[1:0], upd_pc[31:LHT_IDX_BITS+2], upd_pc[1:0]};
  assign pred_hist = lht_q[pred_idx];
  assign pred_taken = pht_q[pred_hist][1];
  // history shifts from the live table entry; the PHT counter is the one named by the fetch snapshot
  assign lht_d = {lht_q[upd_idx][HIST_BITS-2:0], upd_br_en};
  assign pht_cur = pht_q[upd_hist];
  assign miss = upd_br_en != upd_pred_taken;
  always_comb begin
    pht_d = upd_br_en ? ((pht_cur == 2'd3) ? 2'd3 : pht_cur + 2'd1)
                      : ((pht_cur == 2'd0) ? 2'd0 : pht_cur - 2'd1);
    branch_cnt_d = (&branch_cnt_q) ? branch_cnt_q : branch_cnt_q + 32'd1;
    mispred_cnt_d = (&mispred_cnt_q) ? mispred_cnt_q : mispred_cnt_q + 32'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LHT_N; i++) lht_q[i] <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'd1;
      mispredict_q <= 1'b0;
      branch_cnt_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      mispredict_q <= upd_valid && miss;
      if (upd_valid) begin
        lht_q[upd_idx] <= lht_d;
        pht_q[upd_hist] <= pht_d;
        branch_cnt_q <= branch_cnt_d;
        if (miss) mispred_cnt_q <= mispred_cnt_d;
      end
    end
  end
  assign mispredict = mispredict_q;
  assign branch_cnt = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_local_branch_predictor.sv
// tb_local_branch_predictor: scoreboard bench for local_branch_predictor
module tb_local_branch_predictor;
  logic clk = 0, rst = 1;
  logic [31:0] pred_pc = 32'h100;
  logic pred_taken;
  logic [3:0] pred_hist;
  logic upd_valid = 0;
  logic [31:0] upd_pc = '0;
  logic upd_br_en = 0;
  logic [3:0] upd_hist = '0;
  logic upd_pred_taken = 0;
  logic mispredict;
  logic [31:0] branch_cnt, mispred_cnt;
  int checks = 0, errors = 0;
  typedef struct packed {logic mp; logic [31:0] bc; logic [31:0] mc;} exp_t;
  exp_t sb[$];
  logic [3:0] m_lht [32];
  logic [1:0] m_pht [16];
  logic [31:0] m_br, m_mc;
  local_branch_predictor dut (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_hist(pred_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_br_en(upd_br_en), .upd_hist(upd_hist),
    .upd_pred_taken(upd_pred_taken), .mispredict(mispredict), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_lht[i] = '0;
    for (int i = 0; i < 16; i++) m_pht[i] = 2'd1;
    m_br = '0;
    m_mc = '0;
    sb.delete();
  endtask
  task automatic drain();
    exp_t e;
    @(posedge clk);
    #1;
    upd_valid = 0;
    upd_pc = 'x;
    upd_hist = 'x;
    if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      chk("mispredict", {31'd0, mispredict}, {31'd0, e.mp});
      chk("branch_cnt", branch_cnt, e.bc);
      chk("mispred_cnt", mispred_cnt, e.mc);
    end
  endtask
  task automatic upd(input logic [31:0] pc, input logic br, input logic [3:0] h, input logic pt);
    int i;
    i = int'(pc[6:2]);
    upd_valid = 1;
    upd_pc = pc;
    upd_br_en = br;
    upd_hist = h;
    upd_pred_taken = pt;
    m_lht[i] = {m_lht[i][2:0], br};
    m_pht[h] = br ? ((m_pht[h] == 2'd3) ? 2'd3 : m_pht[h] + 2'd1)
                  : ((m_pht[h] == 2'd0) ? 2'd0 : m_pht[h] - 2'd1);
    if (m_br != 32'hFFFF_FFFF) m_br++;
    if (br != pt && m_mc != 32'hFFFF_FFFF) m_mc++;
    sb.push_back('{br != pt, m_br, m_mc});
    drain();
  endtask
  task automatic idle();
    upd_valid = 0;
    sb.push_back('{1'b0, m_br, m_mc});
    drain();
  endtask
  task automatic look(input logic [31:0] pc, output logic [3:0] ph, output logic pt);
    logic [3:0] h;
    pred_pc = pc;
    #1;
    h = m_lht[int'(pc[6:2])];
    chk("pred_hist", {28'd0, pred_hist}, {28'd0, h});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, m_pht[h][1]});
    ph = pred_hist;
    pt = pred_taken;
  endtask
  initial begin
    logic [3:0] ph;
    logic pt;
    logic [3:0] old_h;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_hist", {28'd0, pred_hist}, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
    idle();
    upd(32'h100, 1, 4'd0, 0);
    chk("first_mp", {31'd0, mispredict}, 32'd1);
    chk("first_bc", branch_cnt, 32'd1);
    chk("first_mc", mispred_cnt, 32'd1);
    look(32'h100, ph, pt);
    chk("first_hist", {28'd0, ph}, 32'd1);
    chk("first_taken", {31'd0, pt}, 32'd0);
    chk("first_pht0", {30'd0, dut.pht_q[0]}, 32'd2);
    idle();
    for (int k = 0; k < 5; k++) upd(32'h104, 1, 4'd0, 1);
    chk("sat_pht0", {30'd0, dut.pht_q[0]}, 32'd3);
    upd(32'h104, 0, 4'd0, 1);
    chk("desat_pht0", {30'd0, dut.pht_q[0]}, 32'd2);
    look(32'h108, ph, pt);
    chk("desat_taken", {31'd0, pt}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      look(32'h200, ph, pt);
      if (k == 6) begin
        chk("loop_hist", {28'd0, ph}, 32'hF);
        chk("loop_taken", {31'd0, pt}, 32'd1);
      end
      upd(32'h200, 1, ph, pt);
      if (k >= 6) chk("loop_mp", {31'd0, mispredict}, 32'd0);
    end
    for (int k = 0; k < 20; k++) begin
      logic [31:0] mc0;
      mc0 = m_mc;
      look(32'h300, ph, pt);
      upd(32'h300, (k % 2) == 0, ph, pt);
      if (k >= 12) begin
        chk("alt_mp", {31'd0, mispredict}, 32'd0);
        chk("alt_mc", mispred_cnt, mc0);
      end
    end
    look(32'h100, ph, pt);
    old_h = m_lht[0];
    upd_valid = 1;
    upd_pc = 32'h100;
    upd_br_en = ~old_h[0];
    upd_hist = ph;
    upd_pred_taken = pt;
    #1;
    chk("coll_old", {28'd0, pred_hist}, {28'd0, old_h});
    upd(32'h100, ~old_h[0], ph, pt);
    chk("coll_new", {28'd0, pred_hist}, {28'd0, old_h[2:0], ~old_h[0]});
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    m_br = 32'hFFFF_FFFF;
    upd(32'h10C, 1, 4'd3, 1);
    chk("bc_hold", branch_cnt, 32'hFFFF_FFFF);
    upd(32'h200, 0, 4'd3, 1);
    upd_valid = 1;
    upd_pc = 32'h200;
    upd_br_en = 0;
    upd_hist = 4'd7;
    upd_pred_taken = 1;
    pred_pc = 32'h200;
    #2;
    rst = 1;
    #1;
    chk("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("arst_pred_hist", {28'd0, pred_hist}, 32'd0);
    chk("arst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("arst_branch_cnt", branch_cnt, 32'd0);
    chk("arst_mispred_cnt", mispred_cnt, 32'd0);
    @(posedge clk);
    #1;
    upd_valid = 0;
    rst = 0;
    model_reset();
    idle();
    upd(32'h100, 1, 4'd0, 0);
    look(32'h100, ph, pt);
    chk("post_rst_bc", branch_cnt, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
